// File: rtl/controller_poller_pkg.sv
// Shared types and constants for the gamepad poller: FSM state encoding and button/bit-index sizing.
package controller_pkg;

  localparam int CONTROLLER_NUM_BUTTONS = 8;
  localparam int CONTROLLER_BIT_IDX_W   = $clog2(CONTROLLER_NUM_BUTTONS);
  localparam logic [CONTROLLER_BIT_IDX_W-1:0] CONTROLLER_BIT_LAST =
    CONTROLLER_BIT_IDX_W'(CONTROLLER_NUM_BUTTONS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    SHIFT,
    DONE
  } controller_poll_state_t;

  typedef logic [CONTROLLER_NUM_BUTTONS-1:0] buttons_t;

endpackage

// File: rtl/controller_poller_if.sv
// Serial link between the poller (master) and the two gamepads (slave): shared latch/shift strobes, one data line each.
interface controller_poller_if;

  logic controller_latch;
  logic controller_clk_out_enable;
  logic controller_1_data_in_B;
  logic controller_2_data_in_B;

  modport master (
    output controller_latch,
    output controller_clk_out_enable,
    input  controller_1_data_in_B,
    input  controller_2_data_in_B
  );

  modport slave (
    input  controller_latch,
    input  controller_clk_out_enable,
    output controller_1_data_in_B,
    output controller_2_data_in_B
  );

endinterface

// File: rtl/controller_poller_shift_in.sv
// MSB-first 8-bit shift-in register with synchronous clear; the first bit shifted in ends up in bit 7.
module controller_shift_in_m
  import controller_pkg::*;
(
  input  logic     clk,
  input  logic     clear,
  input  logic     shift_enable,
  input  logic     serial,
  output buttons_t q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (shift_enable) begin
      q <= {q[CONTROLLER_NUM_BUTTONS-2:0], serial};
    end
  end

endmodule

// File: rtl/controller_poller.sv
// Gamepad poll master: latch for LATCH_TICKS ticks, shift 8 bits per channel, publish both bytes atomically.
// Poll latency is (LATCH_TICKS + 8) ticks + 1 cycle; one request may queue behind a busy poll, extras merge.
module controller_poller
  import controller_pkg::*;
#(
  parameter int LATCH_TICKS = 1
) (
  input  logic                 clk_5,
  input  logic                 rst,
  input  logic                 controller_clk_in_enable,
  input  logic                 poll_start,
  controller_poller_if.master  ctrl,
  output buttons_t             controller_1_buttons_out,
  output buttons_t             controller_2_buttons_out,
  output logic                 busy,
  output logic                 poll_done
);

  localparam logic [3:0] LATCH_LAST = 4'(LATCH_TICKS - 1);

  controller_poll_state_t          state;
  logic                            pending;
  logic [3:0]                      latch_cnt;
  logic [CONTROLLER_BIT_IDX_W-1:0] bit_idx;
  logic                            tick;
  logic                            accept;
  logic                            shift_en;
  buttons_t                        sr_1;
  buttons_t                        sr_2;

  assign tick     = controller_clk_in_enable;
  assign accept   = (state == IDLE) && tick && (pending || poll_start);
  assign shift_en = !rst && tick && (state == SHIFT);

  // Data lines are active-low; invert so the registers hold 1 = pressed.
  controller_shift_in_m u_shift_1 (
    .clk          (clk_5),
    .clear        (rst),
    .shift_enable (shift_en),
    .serial       (~ctrl.controller_1_data_in_B),
    .q            (sr_1)
  );

  controller_shift_in_m u_shift_2 (
    .clk          (clk_5),
    .clear        (rst),
    .shift_enable (shift_en),
    .serial       (~ctrl.controller_2_data_in_B),
    .q            (sr_2)
  );

  always_ff @(posedge clk_5) begin
    if (rst) begin
      state                          <= IDLE;
      pending                        <= 1'b0;
      latch_cnt                      <= '0;
      bit_idx                        <= '0;
      ctrl.controller_latch          <= 1'b0;
      ctrl.controller_clk_out_enable <= 1'b0;
      busy                           <= 1'b0;
      poll_done                      <= 1'b0;
      controller_1_buttons_out       <= '0;
      controller_2_buttons_out       <= '0;
    end else begin
      ctrl.controller_clk_out_enable <= 1'b0;
      poll_done                      <= 1'b0;

      // A request arriving on the accepting tick is consumed by that acceptance.
      if (accept) begin
        pending <= 1'b0;
      end else if (poll_start) begin
        pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state                 <= LATCH;
            ctrl.controller_latch <= 1'b1;
            busy                  <= 1'b1;
            latch_cnt             <= '0;
          end
        end
        LATCH: begin
          if (tick) begin
            latch_cnt <= latch_cnt + 4'd1;
            if (latch_cnt == LATCH_LAST) begin
              ctrl.controller_latch <= 1'b0;
              bit_idx               <= '0;
              state                 <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (tick) begin
            ctrl.controller_clk_out_enable <= 1'b1;
            bit_idx                        <= bit_idx + 1'b1;
            if (bit_idx == CONTROLLER_BIT_LAST) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          controller_1_buttons_out <= sr_1;
          controller_2_buttons_out <= sr_2;
          poll_done                <= 1'b1;
          busy                     <= 1'b0;
          state                    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_poller.sv
// Bench for controller_poller: two gamepad models per DUT, a default build and a LATCH_TICKS=3 build,
// expected bytes queued at poll issue and popped by a monitor on each poll_done.
module tb_controller_poller;
  import controller_pkg::*;

  logic clk_5 = 1'b0;
  logic rst   = 1'b1;
  logic tick;
  int   tick_cnt = 0;
  int   cyc      = 0;

  always #5 clk_5 = ~clk_5;

  always @(posedge clk_5) begin
    cyc      <= cyc + 1;
    tick_cnt <= (tick_cnt == 99) ? 0 : tick_cnt + 1;
  end
  assign tick = (tick_cnt == 99);

  logic     ps0 = 1'b0;
  logic     ps1 = 1'b0;
  buttons_t b1_0, b2_0, b1_1, b2_1;
  logic     busy0, busy1, done0, done1;

  controller_poller_if cif0 ();
  controller_poller_if cif1 ();

  controller_poller u_dut (
    .clk_5                    (clk_5),
    .rst                      (rst),
    .controller_clk_in_enable (tick),
    .poll_start               (ps0),
    .ctrl                     (cif0.master),
    .controller_1_buttons_out (b1_0),
    .controller_2_buttons_out (b2_0),
    .busy                     (busy0),
    .poll_done                (done0)
  );

  controller_poller #(.LATCH_TICKS(3)) u_dut3 (
    .clk_5                    (clk_5),
    .rst                      (rst),
    .controller_clk_in_enable (tick),
    .poll_start               (ps1),
    .ctrl                     (cif1.master),
    .controller_1_buttons_out (b1_1),
    .controller_2_buttons_out (b2_1),
    .busy                     (busy1),
    .poll_done                (done1)
  );

  // Gamepad models: parallel-load the active-low button image while latch is high, shift on clk enable.
  logic [7:0] ld  [4];
  logic [7:0] msr [4];

  initial begin
    for (int k = 0; k < 4; k++) begin
      ld[k]  = 8'hFF;
      msr[k] = 8'hFF;
    end
  end

  always @(posedge clk_5) begin
    if (cif0.controller_latch) begin
      msr[0] <= ld[0];
      msr[1] <= ld[1];
    end else if (cif0.controller_clk_out_enable) begin
      msr[0] <= {msr[0][6:0], 1'b1};
      msr[1] <= {msr[1][6:0], 1'b1};
    end
    if (cif1.controller_latch) begin
      msr[2] <= ld[2];
      msr[3] <= ld[3];
    end else if (cif1.controller_clk_out_enable) begin
      msr[2] <= {msr[2][6:0], 1'b1};
      msr[3] <= {msr[3][6:0], 1'b1};
    end
  end

  assign cif0.controller_1_data_in_B = msr[0][7];
  assign cif0.controller_2_data_in_B = msr[1][7];
  assign cif1.controller_1_data_in_B = msr[2][7];
  assign cif1.controller_2_data_in_B = msr[3][7];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [15:0] q0[$];
  logic [15:0] q1[$];

  // Monitor state, indexed by DUT (0 = default build, 1 = LATCH_TICKS=3 build).
  int   rise_cyc  [2] = '{0, 0};
  int   prev_rise [2] = '{0, 0};
  int   latch_len [2] = '{0, 0};
  int   en_cnt    [2] = '{0, 0};
  int   perr      [2] = '{0, 0};
  int   done_cnt  [2] = '{0, 0};
  logic latch_p   [2] = '{1'b0, 1'b0};
  logic tick_p = 1'b0;
  logic        m_l, m_e, m_d;
  logic [15:0] m_got, m_exp;
  int          m_lt;

  always @(negedge clk_5) begin
    for (int i = 0; i < 2; i++) begin
      m_l   = (i == 0) ? cif0.controller_latch : cif1.controller_latch;
      m_e   = (i == 0) ? cif0.controller_clk_out_enable : cif1.controller_clk_out_enable;
      m_d   = (i == 0) ? done0 : done1;
      m_got = (i == 0) ? {b1_0, b2_0} : {b1_1, b2_1};
      m_lt  = (i == 0) ? 1 : 3;
      if (rst) begin
        latch_p[i]   = 1'b0;
        latch_len[i] = 0;
        en_cnt[i]    = 0;
        perr[i]      = 0;
      end else begin
        if (m_l && !latch_p[i]) begin
          prev_rise[i] = rise_cyc[i];
          rise_cyc[i]  = cyc;
          latch_len[i] = 0;
          en_cnt[i]    = 0;
          perr[i]      = 0;
        end
        if (m_l) latch_len[i]++;
        if (!m_l && latch_p[i]) check("latch_width", latch_len[i], m_lt * 100);
        if (m_e && (m_l || !tick_p)) perr[i]++;
        if (m_e) en_cnt[i]++;
        if (m_d) begin
          done_cnt[i]++;
          if (i == 0 && q0.size() == 0) check("unexpected_done0", 1, 0);
          else if (i == 1 && q1.size() == 0) check("unexpected_done1", 1, 0);
          else begin
            m_exp = (i == 0) ? q0.pop_front() : q1.pop_front();
            check("buttons", m_got, m_exp);
          end
          check("clk_en_pulses", en_cnt[i], 8);
          check("clk_en_protocol", perr[i], 0);
          check("latency", cyc - rise_cyc[i], (m_lt + 8) * 100 + 1);
        end
        latch_p[i] = m_l;
      end
    end
    tick_p = tick;
  end

  task automatic pulse(input int i);
    @(posedge clk_5);
    #1;
    if (i == 0) ps0 = 1'b1;
    else        ps1 = 1'b1;
    @(posedge clk_5);
    #1;
    ps0 = 1'b0;
    ps1 = 1'b0;
  endtask

  task automatic wait_done(input int i, input int n, input int max);
    int k;
    k = 0;
    while (done_cnt[i] < n && k < max) begin
      @(negedge clk_5);
      k++;
    end
    if (done_cnt[i] < n) check("timeout_done", 0, 1);
  endtask

  task automatic wait_shift_bits(input int n, input int max);
    int k;
    k = 0;
    do begin
      @(negedge clk_5);
      k++;
    end while (!(busy0 && !cif0.controller_latch && en_cnt[0] >= n) && k < max);
    if (k >= max) check("timeout_shift", 0, 1);
  endtask

  task automatic issue(input int i, input logic [7:0] p1, input logic [7:0] p2);
    ld[2*i]   = ~p1;
    ld[2*i+1] = ~p2;
    if (i == 0) q0.push_back({p1, p2});
    else        q1.push_back({p1, p2});
    pulse(i);
  endtask

  int dc;

  initial begin
    repeat (3) @(posedge clk_5);
    @(negedge clk_5);
    check("rst_latch", cif0.controller_latch, 0);
    check("rst_clk_en", cif0.controller_clk_out_enable, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_buttons", {b1_0, b2_0}, 16'h0000);
    #1 rst = 1'b0;

    // Basic poll with a mid-SHIFT button change: outputs must stay at the reset value until poll_done.
    issue(0, 8'b10001001, 8'b00100110);
    wait_shift_bits(4, 1500);
    ld[0] = 8'h00;
    ld[1] = 8'h00;
    check("atomic_hold", {b1_0, b2_0}, 16'h0000);
    check("busy_mid", busy0, 1);
    wait_done(0, 1, 1500);

    // One start, then two more requests while busy: exactly one extra poll, back to back.
    dc = done_cnt[0];
    issue(0, 8'hA5, 8'h3C);
    repeat (150) @(posedge clk_5);
    q0.push_back({8'hA5, 8'h3C});
    pulse(0);
    repeat (50) @(posedge clk_5);
    pulse(0);
    wait_done(0, dc + 2, 2500);
    check("queued_start_gap", rise_cyc[0] - prev_rise[0], 1000);
    repeat (1200) @(posedge clk_5);
    check("no_third_poll", done_cnt[0], dc + 2);
    check("queue_drained", q0.size(), 0);

    // Reset during SHIFT bit 4: everything returns to reset values on the next edge.
    issue(0, 8'h5A, 8'hC3);
    wait_shift_bits(4, 1500);
    @(posedge clk_5);
    #1 rst = 1'b1;
    q0.delete();
    @(posedge clk_5);
    @(negedge clk_5);
    check("midrst_latch", cif0.controller_latch, 0);
    check("midrst_clk_en", cif0.controller_clk_out_enable, 0);
    check("midrst_busy", busy0, 0);
    check("midrst_buttons", {b1_0, b2_0}, 16'h0000);
    @(posedge clk_5);
    #1 rst = 1'b0;
    repeat (250) @(posedge clk_5);
    check("midrst_no_restart", busy0, 0);
    dc = done_cnt[0];
    issue(0, 8'h5A, 8'hC3);
    wait_done(0, dc + 1, 1500);

    // All pressed, then none pressed.
    issue(0, 8'hFF, 8'hFF);
    wait_done(0, dc + 2, 1500);
    issue(0, 8'h00, 8'h00);
    wait_done(0, dc + 3, 1500);

    // LATCH_TICKS=3 build: 11 ticks + 1 cycle.
    issue(1, 8'h81, 8'h7E);
    wait_done(1, 1, 1700);
    check("dut3_idle", busy1, 0);

    repeat (5) @(posedge clk_5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controller_poller.md
# controller_poller

FPGA-side controller master that sits directly upstream of the CPU's controller registers and downstream of the two serial gamepads (`controller_m`). On each poll request it raises `controller_latch`, then issues eight shift-clock enables while sampling both active-low serial data lines. It delivers two parallel, active-high button bytes, updated atomically at the end of a complete poll, for the CPU read decode at 0x7002/0x7003.

## Interface
Parameters:
- `LATCH_TICKS`, default 1: number of poll ticks `controller_latch` is held high; legal range 1..15.

Ports:
- `clk_5` in 1: system clock. The only clock.
- `rst` in 1: reset, synchronous and active-high.
- `controller_clk_in_enable` in 1: poll tick, one `clk_5` cycle wide. Produced by `clk_mask_m #(100)`, so one tick every 100 cycles.
- `poll_start` in 1: one-cycle poll request, e.g. at vblank.
- `controller_1_data_in_B` in 1: serial data from controller 1, active-low.
- `controller_2_data_in_B` in 1: serial data from controller 2, active-low.
- `controller_latch` out 1: parallel-load strobe to both controllers.
- `controller_clk_out_enable` out 1: one-cycle shift enable to both controllers.
- `controller_1_buttons_out` out 8: last completed controller 1 sample, 1 = pressed.
- `controller_2_buttons_out` out 8: last completed controller 2 sample, 1 = pressed.
- `busy` out 1: high from poll acceptance until completion.
- `poll_done` out 1: one-cycle pulse when the button outputs update.

## Operation
- FSM states: IDLE, LATCH, SHIFT, DONE. All state advances occur only on cycles with `controller_clk_in_enable`=1, except DONE, which lasts exactly one `clk_5` cycle.
- `pending` flag:
  - Set by `poll_start` in any state.
  - Cleared when IDLE accepts a request.
  - At most one request is queued; extra requests while pending are merged.
- IDLE:
  - On a tick with `pending`=1 (or `poll_start`=1 in the same cycle): go to LATCH, set `controller_latch`=1, `busy`=1, latch counter=0.
- LATCH:
  - Each tick increments the latch counter.
  - On the tick where the counter reaches `LATCH_TICKS`: drop `controller_latch`, bit index=0, go to SHIFT.
- SHIFT, on each tick:
  - Shift `~controller_N_data_in_B` into each channel's shift register, MSB-first: sr <= {sr[6:0], bit}. The first serial bit ends in bit 7.
  - Assert `controller_clk_out_enable` for that same single cycle.
  - Increment the bit index.
  - After the 8th sample, go to DONE.
  - Exactly 8 clock-enable pulses are issued per poll.
- DONE:
  - Copy both shift registers to the `*_buttons_out` outputs.
  - Pulse `poll_done`, clear `busy`, go to IDLE.
- Button outputs change only in DONE; they are never partially updated.
- Data lines are sampled only on tick cycles; values between ticks are don't-care.

## Timing
- Reset values: `controller_latch`=0, `controller_clk_out_enable`=0, `busy`=0, `poll_done`=0, both `buttons_out`=8'h00. Also `pending`=0 and state=IDLE.
- `controller_clk_out_enable` is registered, so it goes high in the cycle after the sampling tick edge. Controller shift therefore occurs after the sample, never before it.
- `controller_latch` is registered; it rises on the acceptance tick and falls `LATCH_TICKS` ticks later.
- Latency from acceptance tick to `poll_done`: (LATCH_TICKS + 8) ticks + 1 `clk_5` cycle. With defaults this is 9×100+1 = 901 cycles.
- `poll_start` coincident with a tick in IDLE is accepted on that tick.
- `poll_start` during busy is queued. The next poll begins on the first tick after DONE, never in the DONE cycle itself.
- `rst` mid-poll:
  - All outputs return to reset values on the next edge, including `controller_latch` dropping immediately.
  - The partial shift is discarded and `pending` is cleared.
- `rst` has priority over `poll_start` and ticks in the same cycle.

## Structure
- Package `controller_pkg`:
  - `controller_poll_state_t` enum (IDLE, LATCH, SHIFT, DONE).
  - Constant `CONTROLLER_NUM_BUTTONS` = 8.
  - Bit-index width `$clog2(8)` = 3.
- Sub-module `controller_shift_in_m`: 8-bit shift-in register with `shift_enable`, `clear` and parallel output. Instantiated once per channel.
- The FSM and counters live in the top of this block.
- Target size: ~150–200 lines.

## Test plan
- Reset then one poll:
  - Stimulus: two `controller_m` models loaded with ~8'b10001001 and ~8'b00100110; pulse `poll_start`.
  - Required: `controller_1_buttons_out`=8'b10001001 and `controller_2_buttons_out`=8'b00100110 on `poll_done`. Latency is 901 cycles from the acceptance tick; exactly 8 clk-enable pulses.
- Protocol check:
  - `controller_latch` is high for exactly `LATCH_TICKS` ticks (100 cycles at default).
  - No clk-enable pulse occurs while latch is high.
  - Each clk-enable pulse falls one cycle after a tick.
- Atomicity:
  - Stimulus: change button inputs mid-SHIFT.
  - Required: outputs hold the previous values (8'h00 after reset) until `poll_done`, then show the values latched at LATCH.
- Queued request:
  - Stimulus: pulse `poll_start` twice during busy.
  - Required: exactly one extra poll starts on the first tick after DONE; two `poll_done` pulses total.
- Reset mid-poll:
  - Stimulus: assert `rst` during SHIFT bit 4.
  - Required: next cycle latch=0, `busy`=0, outputs 8'h00. A subsequent poll returns correct bytes.
- All-pressed / none-pressed:
  - Required: outputs 8'hFF and 8'h00 respectively.
  - `LATCH_TICKS`=3 build: latency is 11 ticks + 1 cycle.
